aclint_apb: RTL and testbench
=============================

# aclint_apb

Multi-hart, parametrised successor to the single-hart core-local interruptor. It provides one shared 64-bit MTIME counter with a programmable-ratio prescaler, per-hart MTIMECMP and MSIP registers, and per-hart timer and software interrupt outputs. It sits on the APB uncore bus alongside the PLIC and drives the privileged-unit interrupt inputs of every hart.

## Interface
- P, none, cvw_t configuration; only P.XLEN (32 or 64) is used.
- NHARTS, 1, number of harts (1–16); sizes the MSIP, MTIMECMP and interrupt vectors.
- TICKDIV, 1, PCLK cycles per MTIME increment (1–65536); 1 means increment every cycle.
- PCLK  in  1  APB and timer clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  16  byte offset within the block.
- PWDATA  in  P.XLEN  write data.
- PSTRB  in  P.XLEN/8  byte write strobes.
- PRDATA  out  P.XLEN  registered read data.
- PREADY  out  1  tied to 1.
- MTIME  out  64  current time value, routed to the CSR time/timeh shadow.
- MTimerInt  out  NHARTS  bit h set while MTIME >= MTIMECMP[h] (unsigned).
- MSwInt  out  NHARTS  bit h equals MSIP[h].

## Operation
- Address map (offset → register):
  - 0x0000 + 4h → MSIP[h]. Only bit 0 is writable; other bits read 0.
  - 0x4000 + 8h → MTIMECMP[h] low word; 0x4004 + 8h → high word (XLEN=32 only).
  - 0xBFF8 → MTIME low word; 0xBFFC → MTIME high word (XLEN=32 only).
- Decoding: entry = PADDR word-aligned to XLEN/8 bytes. Hart index h = entry bits above the 4-byte stride (MSIP) or 8-byte stride (MTIMECMP).
- Unmapped offsets, including h >= NHARTS: reads return 0, writes are ignored, no error.
- Write strobe: memwrite = PSEL & PENABLE & PWRITE. Only bytes with PSTRB[i]=1 are updated.
- Reads: every PCLK edge, PRDATA <= value at the current entry. Since PADDR is held from setup to access, PRDATA is valid in the access phase.
- Prescaler: counter pc runs 0..TICKDIV-1; tick = (pc == TICKDIV-1). On tick, pc <= 0 and MTIME <= MTIME+1. Otherwise pc <= pc+1. When TICKDIV=1, tick is constant 1 and pc is optimised away.
- MTIME write (any strobed byte) takes priority over the increment in that cycle and clears pc to 0. The next increment occurs TICKDIV cycles later.
- XLEN=32 high-word write: upper 32 bits are written, lower 32 bits are held (no increment) in that cycle.
- Wrap: MTIME 0xFFFF_FFFF_FFFF_FFFF + tick → 0. No sticky state; MTimerInt re-evaluates immediately.
- Reset values:
  - MSIP = 0 and MTIMECMP = all-ones, for every hart. MTIMECMP is reset to all-ones to prevent spurious timer interrupts.
  - MTIME = 0, pc = 0, PRDATA = 0.
  - Resulting outputs: MTimerInt = 0, MSwInt = 0.
- Reset asserted mid-transfer: the write is aborted and all state goes to reset values asynchronously.

## Timing
- Register write is visible one cycle after the access-phase edge.
- MSwInt and MTimerInt are combinational from registers: MSwInt rises one cycle after the access edge; MTimerInt is asserted in the cycle after MTIMECMP or MTIME is updated.
- Read latency is one cycle (registered PRDATA). PREADY=1 at all times, so there are no wait states.
- Simultaneous tick and MTIME write: the write wins and that tick is lost.
- Simultaneous tick and MTIMECMP write: both take effect; the compare uses the new values next cycle.

## Structure
- Put ACLINT_MSIP_BASE, ACLINT_MTIMECMP_BASE and ACLINT_MTIME_OFF as localparams in the cvw package, so the PLIC and the testbench share the address map.
- Sub-module aclint_timebase(PCLK, PRESETn, TICKDIV param, we_lo, we_hi, wd, strb, MTIME). It holds the prescaler and the MTIME counter with its write-priority logic.
- MSIP and MTIMECMP are generate-loop arrays indexed by hart.

## Test plan
- Reset with NHARTS=4, TICKDIV=1 → MTIME=0, all MTimerInt=0, MSwInt=0; read 0x4008 returns all-ones.
- TICKDIV=4: after reset, hold 40 cycles → MTIME=10. Write MTIME=0x100 → it reads 0x100 for 4 cycles, then 0x101.
- Write MTIMECMP[2]=0x20 with MTIME counting from 0 (TICKDIV=1) → MTimerInt=4'b0100 from MTIME=0x20 onward; other bits stay 0.
- Write 1 to 0x000C, then 0 → MSwInt[3] pulses for exactly the cycles between the two writes. A write to 0x0010 (h=4) is ignored and reads back 0.
- XLEN=32: write MTIME high=0xFFFFFFFF, low=0xFFFFFFFE → two ticks later MTIME=0; MTimerInt for MTIMECMP=0x1 clears at the wrap.
- Partial strobe: PSTRB=0x01, PWDATA=0xAB to 0x4000 → MTIMECMP[0]=0xFFFF_FFFF_FFFF_FFAB. Assert PRESETn low mid-write → MTIMECMP[0] returns to all-ones.

Source files
------------

// File: rtl/aclint_apb_pkg.sv
// Shared configuration type and ACLINT address map, imported by the ACLINT
// RTL and by anything that needs to decode the same offsets.
package aclint_apb_pkg;

    typedef struct packed {
        int XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32};

    localparam logic [15:0] ACLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] ACLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] ACLINT_MTIME_OFF     = 16'hBFF8;

    // Word-align a byte offset to the bus width (bytes = XLEN/8).
    function automatic logic [15:0] align_addr(input logic [15:0] a, input int bytes);
        return a & ~16'(bytes - 1);
    endfunction

endpackage

// File: rtl/aclint_timebase.sv
// Shared MTIME counter with a TICKDIV prescaler; a bus write to any MTIME
// byte wins over the increment in that cycle and restarts the prescaler.
module aclint_timebase #(
    parameter int TICKDIV = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [63:0] wd,
    input  logic [7:0]  strb,
    output logic [63:0] MTIME
);

    logic [7:0] be;
    logic       wr;
    logic       tick;

    assign be = strb & {{4{we_hi}}, {4{we_lo}}};
    assign wr = |be;

    if (TICKDIV > 1) begin : g_pc
        localparam int PCW = $clog2(TICKDIV);
        logic [PCW-1:0] pc;

        assign tick = (pc == PCW'(TICKDIV - 1));

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn)        pc <= '0;
            else if (wr || tick) pc <= '0;
            else                 pc <= pc + PCW'(1);
        end
    end else begin : g_nopc
        assign tick = 1'b1;
    end

    // Bytes not selected by the write hold their value; no increment that cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            MTIME <= '0;
        end else if (wr) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) MTIME[8*b +: 8] <= wd[8*b +: 8];
        end else if (tick) begin
            MTIME <= MTIME + 64'd1;
        end
    end

endmodule

// File: rtl/aclint_apb.sv
// Multi-hart ACLINT on APB: per-hart MSIP and MTIMECMP, shared MTIME,
// registered read data and combinational interrupt outputs.
module aclint_apb
    import aclint_apb_pkg::*;
#(
    parameter cvw_t P       = CVW_DEFAULT,
    parameter int   NHARTS  = 1,
    parameter int   TICKDIV = 1
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [15:0]         PADDR,
    input  logic [P.XLEN-1:0]   PWDATA,
    input  logic [P.XLEN/8-1:0] PSTRB,
    output logic [P.XLEN-1:0]   PRDATA,
    output logic                PREADY,
    output logic [63:0]         MTIME,
    output logic [NHARTS-1:0]   MTimerInt,
    output logic [NHARTS-1:0]   MSwInt
);

    localparam int XLEN = P.XLEN;
    localparam int NB   = XLEN / 8;

    logic        memwrite;
    logic [15:0] entry;
    logic [63:0] wd64;
    logic [7:0]  strb64;
    logic [63:0] hart_rd [NHARTS];
    logic [63:0] mtime_rd;
    logic [63:0] rd64;
    logic [XLEN-1:0] rd_x;
    logic        mt_lo, mt_hi;

    // Everything is handled in 64-bit lanes; with XLEN=32 the bus word is
    // replicated so the upper lane sees the same data and strobes.
    assign memwrite = PSEL & PENABLE & PWRITE;
    assign entry    = align_addr(PADDR, NB);
    assign wd64     = {(64/XLEN){PWDATA}};
    assign strb64   = {(64/XLEN){PSTRB}};
    assign PREADY   = 1'b1;

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        localparam logic [15:0] MSIP_A = ACLINT_MSIP_BASE + 16'(4 * h);
        localparam logic [15:0] CMP_A  = ACLINT_MTIMECMP_BASE + 16'(8 * h);
        localparam int          ML     = h % 2;

        logic        msip_q, msip_sel, cmp_lo, cmp_hi;
        logic [7:0]  cmp_be;
        logic [63:0] cmp_q;

        assign msip_sel = (entry == align_addr(MSIP_A, NB));
        assign cmp_lo   = (entry == CMP_A);
        assign cmp_hi   = (entry == align_addr(CMP_A + 16'd4, NB));
        assign cmp_be   = strb64 & {{4{memwrite & cmp_hi}}, {4{memwrite & cmp_lo}}};

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn)
                msip_q <= 1'b0;
            else if (memwrite && msip_sel && strb64[4*ML])
                msip_q <= wd64[32*ML];
        end

        // All-ones reset keeps MTimerInt low until software programs a compare.
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                cmp_q <= '1;
            end else begin
                for (int b = 0; b < 8; b++)
                    if (cmp_be[b]) cmp_q[8*b +: 8] <= wd64[8*b +: 8];
            end
        end

        assign MSwInt[h]    = msip_q;
        assign MTimerInt[h] = (MTIME >= cmp_q);
        assign hart_rd[h]   = {(cmp_hi ? cmp_q[63:32] : 32'h0), (cmp_lo ? cmp_q[31:0] : 32'h0)}
                            | (msip_sel ? (64'(msip_q) << (32 * ML)) : 64'h0);
    end

    assign mt_lo = (entry == ACLINT_MTIME_OFF);
    assign mt_hi = (entry == align_addr(ACLINT_MTIME_OFF + 16'd4, NB));

    aclint_timebase #(.TICKDIV(TICKDIV)) u_timebase (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we_lo   (memwrite & mt_lo),
        .we_hi   (memwrite & mt_hi),
        .wd      (wd64),
        .strb    (strb64),
        .MTIME   (MTIME)
    );

    assign mtime_rd = {(mt_hi ? MTIME[63:32] : 32'h0), (mt_lo ? MTIME[31:0] : 32'h0)};

    always_comb begin
        rd64 = mtime_rd;
        for (int h = 0; h < NHARTS; h++) rd64 = rd64 | hart_rd[h];
    end

    if (XLEN == 64) begin : g_rd64
        assign rd_x = rd64[XLEN-1:0];
    end else begin : g_rd32
        assign rd_x = rd64[XLEN-1:0] | rd64[63:64-XLEN];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) PRDATA <= '0;
        else          PRDATA <= rd_x;
    end

endmodule

// File: tb/tb_aclint_apb.sv
// Directed bench for aclint_apb: two XLEN=32, 4-hart instances, one with
// TICKDIV=1 (dut_a) and one with TICKDIV=4 (dut_b), on a shared APB bus.
module tb_aclint_apb;
    import aclint_apb_pkg::*;

    localparam cvw_t CFG = '{XLEN: 32};
    localparam int   NH  = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic        psel_a = 1'b0;
    logic        psel_b = 1'b0;
    logic [15:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic [63:0] mtime_a, mtime_b;
    logic [NH-1:0] mti_a, msi_a, mti_b, msi_b;
    logic [31:0] rdata;
    int          tests = 0;
    int          fails = 0;

    always #5 PCLK = ~PCLK;

    aclint_apb #(.P(CFG), .NHARTS(NH), .TICKDIV(1)) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_a), .PREADY(pready_a),
        .MTIME(mtime_a), .MTimerInt(mti_a), .MSwInt(msi_a)
    );

    aclint_apb #(.P(CFG), .NHARTS(NH), .TICKDIV(4)) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_b), .PREADY(pready_b),
        .MTIME(mtime_b), .MTimerInt(mti_b), .MSwInt(msi_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input bit to_b, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        psel_a = !to_b; psel_b = to_b; PWRITE = 1'b1; PENABLE = 1'b0;
        PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    endtask

    task automatic apb_read(input bit to_b, input logic [15:0] a, output logic [31:0] d);
        psel_a = !to_b; psel_b = to_b; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        d = to_b ? prdata_b : prdata_a;
        @(posedge PCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
    endtask

    initial begin
        int n;

        // Reset state, observed while reset is still held
        tick(1);
        check("rst_mtime_a", mtime_a, 64'h0);
        check("rst_mtime_b", mtime_b, 64'h0);
        check("rst_mti_a", 64'(mti_a), 64'h0);
        check("rst_msi_a", 64'(msi_a), 64'h0);
        check("rst_prdata_a", 64'(prdata_a), 64'h0);
        check("pready_a", 64'(pready_a), 64'h1);
        PRESETn = 1'b1;
        apb_read(1'b0, 16'h4008, rdata);
        check("rst_cmp1_lo", 64'(rdata), 64'hFFFF_FFFF);
        apb_read(1'b0, 16'h400C, rdata);
        check("rst_cmp1_hi", 64'(rdata), 64'hFFFF_FFFF);
        apb_read(1'b1, 16'h401C, rdata);
        check("rst_cmp3_hi_b", 64'(rdata), 64'hFFFF_FFFF);

        // Prescaler: 40 cycles after reset
        do_reset();
        tick(40);
        check("div4_40cyc", mtime_b, 64'd10);
        check("div1_40cyc", mtime_a, 64'd40);
        apb_write(1'b1, ACLINT_MTIME_OFF, 32'h100, 4'hF);
        check("div4_wr_c0", mtime_b, 64'h100);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check("div4_wr_hold", mtime_b, 64'h100);
        end
        tick(1);
        check("div4_wr_inc", mtime_b, 64'h101);

        // Read latency: PRDATA shows MTIME as of the setup edge
        apb_write(1'b0, ACLINT_MTIME_OFF, 32'h50, 4'hF);
        apb_read(1'b0, ACLINT_MTIME_OFF, rdata);
        check("rd_mtime_lo", 64'(rdata), 64'h50);
        check("mtime_after_rd", mtime_a, 64'h52);

        // Timer compare on hart 2
        do_reset();
        apb_write(1'b0, 16'h4010, 32'h20, 4'hF);
        apb_write(1'b0, 16'h4014, 32'h0, 4'hF);
        check("cmp2_early", 64'(mti_a), 64'h0);
        n = 0;
        while (mtime_a != 64'h1F && n < 200) begin
            tick(1);
            n++;
        end
        check("wait_mtime_1f", mtime_a, 64'h1F);
        check("cmp2_before", 64'(mti_a), 64'h0);
        tick(1);
        check("mtime_20", mtime_a, 64'h20);
        check("cmp2_at", 64'(mti_a), 64'b0100);
        tick(5);
        check("cmp2_after", 64'(mti_a), 64'b0100);

        // Software interrupts
        apb_write(1'b0, 16'h000C, 32'h1, 4'hF);
        check("msip3_set", 64'(msi_a), 64'b1000);
        tick(3);
        check("msip3_hold", 64'(msi_a), 64'b1000);
        apb_read(1'b0, 16'h000C, rdata);
        check("msip3_rd", 64'(rdata), 64'h1);
        apb_write(1'b0, 16'h000C, 32'h0, 4'hF);
        check("msip3_clr", 64'(msi_a), 64'b0000);
        apb_write(1'b0, 16'h0008, 32'hFFFF_FFFF, 4'hF);
        check("msip2_set", 64'(msi_a), 64'b0100);
        apb_read(1'b0, 16'h0008, rdata);
        check("msip2_rd_bit0", 64'(rdata), 64'h1);
        apb_write(1'b0, 16'h0010, 32'h1, 4'hF);
        check("msip4_ignored", 64'(msi_a), 64'b0100);
        apb_read(1'b0, 16'h0010, rdata);
        check("msip4_rd", 64'(rdata), 64'h0);
        apb_read(1'b0, 16'h4020, rdata);
        check("cmp4_rd", 64'(rdata), 64'h0);
        check("b_msi_untouched", 64'(msi_b), 64'h0);

        // Wrap of MTIME with hart 1 compare = 1
        do_reset();
        apb_write(1'b0, 16'h4008, 32'h1, 4'hF);
        apb_write(1'b0, 16'h400C, 32'h0, 4'hF);
        check("cmp1_one", 64'(mti_a), 64'b0010);
        apb_write(1'b0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        apb_write(1'b0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        check("wrap_pre", mtime_a, 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_pre_mti", 64'(mti_a), 64'b0010);
        tick(1);
        check("wrap_max", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_max_mti", 64'(mti_a), 64'b1111);
        tick(1);
        check("wrap_zero", mtime_a, 64'h0);
        check("wrap_zero_mti", 64'(mti_a), 64'b0000);

        // Partial strobe, then reset in the middle of a write
        do_reset();
        apb_write(1'b0, 16'h4000, 32'h0000_00AB, 4'b0001);
        apb_read(1'b0, 16'h4000, rdata);
        check("pstrb_lo", 64'(rdata), 64'hFFFF_FFAB);
        apb_read(1'b0, 16'h4004, rdata);
        check("pstrb_hi", 64'(rdata), 64'hFFFF_FFFF);
        psel_a = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
        PADDR = 16'h4000; PWDATA = 32'h1234_5678; PSTRB = 4'hF;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check("midrst_prdata", 64'(prdata_a), 64'h0);
        check("midrst_mtime", mtime_a, 64'h0);
        @(posedge PCLK); #1;
        psel_a = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
        PRESETn = 1'b1;
        apb_read(1'b0, 16'h4000, rdata);
        check("midrst_cmp0_lo", 64'(rdata), 64'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
